go_seq_gen: RTL and testbench

Serial pattern transmitter that drives the single-bit `go` line of the team's Mealy sequence detectors. It sits on the stimulus side of a detector such as the eight-state `go`/`op` recogniser. On a `start` request it emits a latched WIDTH-bit pattern MSB-first, one bit per clock, and repeats it a programmed number of times with an optional idle gap between repetitions. The default pattern 8'b1011_0101 produces the 1,0,1,1,0,1,0,1 stream that walks a detector from its idle state to its terminal output.

---
 rtl/go_seq_gen_pkg.sv | 20 ++
 rtl/go_seq_gen_shifter.sv | 28 ++
 rtl/go_seq_gen.sv | 126 ++++++++++++
 tb/tb_go_seq_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/go_seq_gen_pkg.sv
// Shared definitions for the go_seq_gen pattern transmitter: state encoding
// and the default detector-walking pattern.
package seq_gen_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_t;

  // Walks the eight-state go/op recogniser from idle to its terminal output.
  localparam logic [7:0] DEFAULT_PATTERN = 8'b1011_0101;

endpackage

// File: rtl/go_seq_gen_shifter.sv
// Loadable left shifter; the MSB is the bit currently presented on go.
module seq_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  // load wins over shift so a reload on the last bit starts the next copy cleanly
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/go_seq_gen.sv
// Serial pattern transmitter for the go line of the Mealy sequence detectors:
// sends a latched pattern MSB-first, repeated with an optional idle gap.
module go_seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             go,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  localparam int BC_W = $clog2(WIDTH + 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(WIDTH);

  // Request/acknowledge: a start seen while busy is low is taken on that edge
  // together with pattern/reps/gap; while busy is high start is ignored.
  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [BC_W-1:0]  bitcnt;
  logic [CNT_W-1:0] repcnt;
  logic [GAP_W-1:0] gapcnt;
  logic [GAP_W-1:0] gap_q;

  logic             accept;
  logic             last_bit;
  logic             last_rep;
  logic             reload_send;
  logic             reload_gap;
  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_din;
  logic             msb;

  always_comb begin
    accept      = (state == IDLE) && start && !abort;
    last_bit    = (bitcnt == BC_W'(1));
    last_rep    = (repcnt <= CNT_W'(1));
    reload_send = (state == SEND) && !abort && last_bit && !last_rep &&
                  (gap_q == '0);
    reload_gap  = (state == GAP) && !abort && (gapcnt == GAP_W'(1));
    sh_load     = accept || reload_send || reload_gap;
    sh_din      = accept ? pattern : pat_q;
    sh_shift    = (state == SEND) && !abort && !sh_load;
  end

  seq_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (sh_din),
    .msb   (msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pat_q  <= '0;
      bitcnt <= '0;
      repcnt <= '0;
      gapcnt <= '0;
      gap_q  <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SEND;
            pat_q  <= pattern;
            repcnt <= (reps == '0) ? CNT_W'(1) : reps;
            gap_q  <= gap;
            bitcnt <= BC_FULL;
          end
        end
        SEND: begin
          if (last_bit) begin
            if (last_rep) begin
              state <= DONE;
            end else if (gap_q == '0) begin
              repcnt <= repcnt - CNT_W'(1);
              bitcnt <= BC_FULL;
            end else begin
              state  <= GAP;
              gapcnt <= gap_q;
              repcnt <= repcnt - CNT_W'(1);
            end
          end else begin
            bitcnt <= bitcnt - BC_W'(1);
          end
        end
        GAP: begin
          if (gapcnt == GAP_W'(1)) begin
            state  <= SEND;
            bitcnt <= BC_FULL;
          end else begin
            gapcnt <= gapcnt - GAP_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign go        = (state == SEND) && msb;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_go_seq_gen.sv
// Bench for go_seq_gen: burst driver, per-cycle expected stream queue checked
// by an independent monitor, and a window detector on the go stream.
module tb_go_seq_gen;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             go;
  logic             busy;
  logic             done;
  logic [1:0]       fsm_state;

  // entry: {end_of_rep, done, go, pattern}
  logic [WIDTH+2:0] exp_q[$];
  int               checks = 0;
  int               errors = 0;
  int               det_fires = 0;
  logic             mon_en = 1'b0;
  logic [WIDTH-1:0] det_win = '0;

  go_seq_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pattern   (pattern),
    .reps      (reps),
    .gap       (gap),
    .abort     (abort),
    .go        (go),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected busy-cycle stream of one burst, built from the burst rules.
  task automatic push_burst(input logic [WIDTH-1:0] pat, input int r_in, input int g,
                            output int len);
    int r;
    r = (r_in == 0) ? 1 : r_in;
    for (int i = 0; i < r; i++) begin
      for (int k = 0; k < WIDTH; k++)
        exp_q.push_back({(k == WIDTH-1), 1'b0, pat[WIDTH-1-k], pat});
      if (i < r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back({3'b000, pat});
    end
    exp_q.push_back({3'b010, pat});
    len = r * WIDTH + (r - 1) * g + 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Called just after the accept edge; counts busy cycles, optional start poke.
  task automatic measure_burst(input string name, input int exp_len, input bit poke);
    int n;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (poke) begin
        start = (n == 3);
        pattern = WIDTH'($urandom);
        reps = CNT_W'($urandom);
        gap = GAP_W'($urandom);
      end
    end
    if (poke) start = 1'b0;
    check(name, n, exp_len);
  endtask

  task automatic run_burst(input string name, input logic [WIDTH-1:0] pat, input int r,
                           input int g, input bit poke);
    int len;
    wait_idle();
    pattern = pat;
    reps = CNT_W'(r);
    gap = GAP_W'(g);
    start = 1'b1;
    push_burst(pat, r, g, len);
    tick();
    start = 1'b0;
    pattern = WIDTH'($urandom);
    reps = CNT_W'($urandom);
    gap = GAP_W'($urandom);
    measure_burst(name, len, poke);
  endtask

  // Monitor: pops one expected entry per busy cycle.
  always @(negedge clk) begin
    logic [WIDTH+2:0] e;
    if (mon_en) begin
      if (busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_busy act=busy exp=idle t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({done, go} !== e[WIDTH+1:WIDTH]) begin
            errors++;
            $display("FAIL stream act_done_go=%b%b exp=%b t=%0t", done, go,
                     e[WIDTH+1:WIDTH], $time);
          end
          det_win = {det_win[WIDTH-2:0], go};
          if (e[WIDTH+2]) begin
            checks++;
            if (det_win !== e[WIDTH-1:0]) begin
              errors++;
              $display("FAIL detector act=%h exp=%h t=%0t", det_win, e[WIDTH-1:0], $time);
            end else if (e[WIDTH-1:0] == 8'hB5) begin
              det_fires++;
            end
          end
        end
      end else begin
        checks++;
        if (go !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs act_go=%b act_done=%b exp=0 t=%0t", go, done, $time);
        end
      end
    end
  end

  initial begin
    int len;
    int fires0;
    logic [WIDTH-1:0] p;
    reset = 1'b1;
    start = 1'b0;
    pattern = '0;
    reps = '0;
    gap = '0;
    abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_go", go, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state", fsm_state, 0);
    mon_en = 1'b1;

    fires0 = det_fires;
    run_burst("b5_r1_len", 8'hB5, 1, 0, 1'b0);
    check("b5_r1_fires", det_fires - fires0, 1);
    fires0 = det_fires;
    run_burst("b5_r2_g3_len", 8'hB5, 2, 3, 1'b0);
    check("b5_r2_fires", det_fires - fires0, 2);
    run_burst("ff_r0_len", 8'hFF, 0, 0, 1'b0);
    run_burst("poke_len", 8'hB5, 3, 0, 1'b1);

    // start held high: re-trigger in the first IDLE cycle after done
    wait_idle();
    pattern = 8'h96;
    reps = 1;
    gap = 0;
    start = 1'b1;
    push_burst(8'h96, 1, 0, len);
    push_burst(8'h96, 1, 0, len);
    tick();
    measure_burst("held_first_len", len, 1'b0);
    tick();
    start = 1'b0;
    measure_burst("held_second_len", len, 1'b0);

    // abort at the 4th bit of a reps=3 burst
    wait_idle();
    p = WIDTH'($urandom);
    pattern = p;
    reps = 3;
    gap = GAP_W'($urandom_range(0, 3));
    start = 1'b1;
    push_burst(p, 3, int'(gap), len);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_state", fsm_state, 0);
    tick();
    tick();
    run_burst("after_abort_len", 8'hB5, 1, 0, 1'b0);

    // abort and start in the same IDLE cycle
    wait_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("abort_start_busy", busy, 0);

    // reset at the 5th bit with start held through it
    wait_idle();
    pattern = 8'hB5;
    reps = 2;
    gap = 1;
    start = 1'b1;
    push_burst(8'hB5, 2, 1, len);
    tick();
    p = WIDTH'($urandom);
    pattern = p;
    reps = 1;
    gap = 0;
    tick();
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    exp_q.delete();
    @(negedge clk);
    check("reset_mid_busy", busy, 0);
    check("reset_mid_go", go, 0);
    tick();
    push_burst(p, 1, 0, len);
    reset = 1'b0;
    tick();
    start = 1'b0;
    measure_burst("after_reset_len", len, 1'b0);

    for (int i = 0; i < 10; i++)
      run_burst("rand_len", WIDTH'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));

    wait_idle();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
